// File: rtl/sbox_layer_iter.sv
// -----------------------------------------------------------------------------
// sbox_layer_iter
//   Iterative ASCON substitution layer (p_S) over the 320-bit permutation state.
//   NB_SBOX bit-columns are substituted per RUN cycle, so a full state takes
//   NB_ITER = 64/NB_SBOX cycles. Valid/ready handshake on both sides.
//
// Ports
//   clock_i   : system clock, rising edge
//   resetb_i  : asynchronous reset, active low
//   start_i   : input state valid (sampled only in IDLE)
//   ready_o   : block can accept a state (IDLE)
//   state_i   : input state {x0,x1,x2,x3,x4}, x0 in [319:256]
//   valid_o   : state_o holds a completed result (DONE)
//   ready_i   : downstream accepts the result (sampled only in DONE)
//   busy_o    : substitution in progress (RUN)
//   state_o   : state register, same layout as state_i
// -----------------------------------------------------------------------------
module sbox_layer_iter #(
   parameter int unsigned NB_SBOX = 16
) (
   input  logic         clock_i,
   input  logic         resetb_i,
   input  logic         start_i,
   output logic         ready_o,
   input  logic [319:0] state_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic         busy_o,
   output logic [319:0] state_o
);

   localparam int unsigned NB_ITER = 64 / NB_SBOX;
   localparam int unsigned CNT_W   = (NB_ITER > 1) ? $clog2(NB_ITER) : 1;

   if (NB_SBOX != 1 && NB_SBOX != 2 && NB_SBOX != 4 && NB_SBOX != 8 &&
       NB_SBOX != 16 && NB_SBOX != 32 && NB_SBOX != 64) begin : g_bad_nb_sbox
      $error("sbox_layer_iter: NB_SBOX must be 1,2,4,8,16,32 or 64");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t               fsm_q, fsm_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [319:0]       st_q, st_d;
   logic               last;
   int unsigned        base;

   // Bit-sliced S-box operands: one bit per column of the current group.
   logic [NB_SBOX-1:0] x0, x1, x2, x3, x4;
   logic [NB_SBOX-1:0] a0, a2, a4;
   logic [NB_SBOX-1:0] b0, b1, b2, b3, b4;

   assign last = (cnt_q == CNT_W'(NB_ITER - 1));

   // ---------------------------------------------------------------------------
   // Substitution of the current column group, everything else passes through.
   // Uses the ASCON bitsliced boolean form instead of a table lookup.
   // ---------------------------------------------------------------------------
   always_comb begin
      base = 32'(cnt_q) * NB_SBOX;
      x0   = st_q[256 + base +: NB_SBOX];
      x1   = st_q[192 + base +: NB_SBOX];
      x2   = st_q[128 + base +: NB_SBOX];
      x3   = st_q[ 64 + base +: NB_SBOX];
      x4   = st_q[       base +: NB_SBOX];

      a0 = x0 ^ x4;
      a4 = x4 ^ x3;
      a2 = x2 ^ x1;

      b0 = a0 ^ (~x1 & a2);
      b1 = x1 ^ (~a2 & x3);
      b2 = a2 ^ (~x3 & a4);
      b3 = x3 ^ (~a4 & a0);
      b4 = a4 ^ (~a0 & x1);

      st_d = st_q;
      st_d[256 + base +: NB_SBOX] = b0 ^ b4;
      st_d[192 + base +: NB_SBOX] = b1 ^ b0;
      st_d[128 + base +: NB_SBOX] = ~b2;
      st_d[ 64 + base +: NB_SBOX] = b3 ^ b2;
      st_d[       base +: NB_SBOX] = b4;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
         IDLE:    if (start_i) fsm_d = RUN;
         RUN:     if (last)    fsm_d = DONE;
         DONE:    if (ready_i) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      ready_o = 1'b0;
      valid_o = 1'b0;
      busy_o  = 1'b0;
      unique case (fsm_q)
         IDLE:    ready_o = 1'b1;
         RUN:     busy_o  = 1'b1;
         DONE:    valid_o = 1'b1;
         default: ready_o = 1'b0;
      endcase
   end

   assign state_o = st_q;

   // ---------------------------------------------------------------------------
   // Datapath: state register and column-group counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         st_q  <= '0;
         cnt_q <= '0;
      end else begin
         unique case (fsm_q)
            IDLE: begin
               if (start_i) begin
                  st_q  <= state_i;
                  cnt_q <= '0;
               end
            end
            RUN: begin
               st_q <= st_d;
               // explicit wrap keeps NB_ITER=1 (1-bit counter) at zero
               cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sbox_layer_iter.sv
// -----------------------------------------------------------------------------
// tb_sbox_layer_iter
//   Directed bench for sbox_layer_iter. Four instances (NB_SBOX = 16, 1, 8, 64)
//   share all inputs; each instance's latency and result are checked
//   individually against hand-computed constants or a table-driven p_S model.
// -----------------------------------------------------------------------------
module tb_sbox_layer_iter;

   localparam int NDUT = 4;
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };

   logic         clk = 1'b0;
   logic         rstb;
   logic         start;
   logic [319:0] state_in;
   logic         ack;

   logic         rdy [NDUT];
   logic         vld [NDUT];
   logic         bsy [NDUT];
   logic [319:0] so  [NDUT];

   int           exp_lat [NDUT] = '{4, 64, 8, 1};
   int           lat     [NDUT];

   int           n_assert = 0;
   int           n_fail   = 0;

   always #5 clk = ~clk;

   sbox_layer_iter #(.NB_SBOX(16)) u_nb16 (
      .clock_i(clk), .resetb_i(rstb), .start_i(start), .ready_o(rdy[0]),
      .state_i(state_in), .valid_o(vld[0]), .ready_i(ack), .busy_o(bsy[0]),
      .state_o(so[0]));
   sbox_layer_iter #(.NB_SBOX(1)) u_nb1 (
      .clock_i(clk), .resetb_i(rstb), .start_i(start), .ready_o(rdy[1]),
      .state_i(state_in), .valid_o(vld[1]), .ready_i(ack), .busy_o(bsy[1]),
      .state_o(so[1]));
   sbox_layer_iter #(.NB_SBOX(8)) u_nb8 (
      .clock_i(clk), .resetb_i(rstb), .start_i(start), .ready_o(rdy[2]),
      .state_i(state_in), .valid_o(vld[2]), .ready_i(ack), .busy_o(bsy[2]),
      .state_o(so[2]));
   sbox_layer_iter #(.NB_SBOX(64)) u_nb64 (
      .clock_i(clk), .resetb_i(rstb), .start_i(start), .ready_o(rdy[3]),
      .state_i(state_in), .valid_o(vld[3]), .ready_i(ack), .busy_o(bsy[3]),
      .state_o(so[3]));

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference p_S: table lookup per column, x0 as MSB of the S-box index.
   function automatic logic [319:0] ps_model(input logic [319:0] s);
      logic [319:0] r;
      logic [4:0]   v;
      r = '0;
      for (int j = 0; j < 64; j++) begin
         v = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
         v = SBOX[v];
         r[256+j] = v[4];
         r[192+j] = v[3];
         r[128+j] = v[2];
         r[ 64+j] = v[1];
         r[     j] = v[0];
      end
      return r;
   endfunction

   // Accept one state on all instances, wait for every instance's valid_o
   // (bounded), check latency and result, optionally complete the handshake.
   task automatic do_txn(input string tag, input logic [319:0] s,
                         input logic [319:0] exp, input bit release_done);
      int cyc;
      bit all_done;
      for (int k = 0; k < NDUT; k++) chk($sformatf("%s_ready_before%0d", tag, k), 320'(rdy[k]), 320'(1));
      state_in = s;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < NDUT; k++) lat[k] = 0;
      cyc = 0;
      all_done = 1'b0;
      while (!all_done && cyc < 80) begin
         @(posedge clk); #1;
         cyc++;
         all_done = 1'b1;
         for (int k = 0; k < NDUT; k++) begin
            if (vld[k] && lat[k] == 0) lat[k] = cyc;
            if (lat[k] == 0) all_done = 1'b0;
         end
      end
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("%s_latency%0d", tag, k), 320'(lat[k]), 320'(exp_lat[k]));
         chk($sformatf("%s_state%0d", tag, k), so[k], exp);
      end
      if (release_done) begin
         ack = 1'b1;
         @(posedge clk); #1;
         ack = 1'b0;
         for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s_ready_after%0d", tag, k), 320'(rdy[k]), 320'(1));
            chk($sformatf("%s_valid_after%0d", tag, k), 320'(vld[k]), 320'(0));
         end
      end
   endtask

   initial begin : stim
      logic [319:0] exp;
      logic [319:0] rnd;

      rstb = 1'b0; start = 1'b0; ack = 1'b0; state_in = '0;

      // Reset values
      #12;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_ready%0d", k), 320'(rdy[k]), 320'(1));
         chk($sformatf("rst_valid%0d", k), 320'(vld[k]), 320'(0));
         chk($sformatf("rst_busy%0d", k),  320'(bsy[k]), 320'(0));
         chk($sformatf("rst_state%0d", k), so[k], '0);
      end
      @(negedge clk); rstb = 1'b1;
      @(posedge clk); #1;

      // T1: zero state -> every column maps 0x00 -> 0x04 (x2 set)
      exp = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
      do_txn("t1", '0, exp, 1'b1);

      // T2: all ones -> every column maps 0x1F -> 0x17
      exp = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      do_txn("t2", '1, exp, 1'b1);

      // T3: only x4[0] set -> column 0 maps 0x01 -> 0x0B, others 0x00 -> 0x04
      exp = {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1};
      do_txn("t3", 320'h1, exp, 1'b1);

      // T4: stall in DONE for 10 cycles with a start pulse that must be ignored
      exp = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      do_txn("t4", '1, exp, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin start = 1'b1; state_in = 320'h1234_5678; end
         if (i == 4) start = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("t4_hold_valid_c%0d", i), 320'(vld[0]), 320'(1));
         chk($sformatf("t4_hold_state_c%0d", i), so[0], exp);
      end
      chk("t4_hold_state_nb1", so[1], exp);
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("t4_ready_next", 320'(rdy[0]), 320'(1));
      chk("t4_valid_next", 320'(vld[0]), 320'(0));
      @(posedge clk); #1;
      chk("t4_busy_idle", 320'(bsy[0]), 320'(0));
      chk("t4_state_kept", so[0], exp);

      // T5: asynchronous reset two cycles into RUN
      state_in = {5{64'hA5A5_0F0F_3C3C_9696}};
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t5_busy_nb16", 320'(bsy[0]), 320'(1));
      chk("t5_busy_nb1",  320'(bsy[1]), 320'(1));
      chk("t5_valid_nb64", 320'(vld[3]), 320'(1));
      #2 rstb = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("t5_ready%0d", k), 320'(rdy[k]), 320'(1));
         chk($sformatf("t5_valid%0d", k), 320'(vld[k]), 320'(0));
         chk($sformatf("t5_busy%0d", k),  320'(bsy[k]), 320'(0));
         chk($sformatf("t5_state%0d", k), so[k], '0);
      end
      @(negedge clk); rstb = 1'b1;
      @(posedge clk); #1;
      do_txn("t5_rerun", '0, {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0}, 1'b1);

      // T6: random states against the table model, all four widths at once
      for (int t = 0; t < 4; t++) begin
         for (int w = 0; w < 10; w++) rnd[w*32 +: 32] = $urandom;
         exp = ps_model(rnd);
         do_txn($sformatf("t6_%0d", t), rnd, exp, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
